// File: rtl/pipelined_bitonic_merge_pkg.sv
// Shared widths, key/index types and the compare-exchange primitive for the bitonic merger.
package pipelined_bitonic_merge_pkg;
    localparam int NETWORK_WIDTH = 8;
    localparam int INDEX_WIDTH   = 4;

    typedef logic [NETWORK_WIDTH-1:0] key_t;
    typedef logic [INDEX_WIDTH-1:0]   idx_t;

    typedef struct packed {
        key_t key;
        idx_t idx;
    } entry_t;

    typedef struct packed {
        entry_t first;
        entry_t second;
    } pair_t;

    // first goes to the lower lane; equal keys keep their order
    function automatic pair_t cmp_swap(input logic dir, input entry_t a, input entry_t b);
        pair_t p;
        if (dir ? (a.key > b.key) : (a.key < b.key)) begin
            p.first  = b;
            p.second = a;
        end else begin
            p.first  = a;
            p.second = b;
        end
        return p;
    endfunction
endpackage

// File: rtl/pipelined_bitonic_merge_stage.sv
// One register rank of the merger: compare-exchange at distance DIST, then enabled flops.
module merge_compare_stage
    import pipelined_bitonic_merge_pkg::*;
#(
    parameter int SIZE = 4,
    parameter int DIST = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  prev_valid,
    input  logic                  prev_dir,
    input  key_t [SIZE-1:0]       prev_data,
    input  idx_t [SIZE-1:0]       prev_index,
    output logic                  valid,
    output logic                  dir,
    output key_t [SIZE-1:0]       data,
    output idx_t [SIZE-1:0]       index
);
    key_t [SIZE-1:0] nxt_data;
    idx_t [SIZE-1:0] nxt_index;

    // Each lane evaluates its own pair so every lane output has exactly one driver.
    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        localparam int J = i ^ DIST;
        pair_t  p;
        entry_t own, partner;
        assign own     = '{key: prev_data[i], idx: prev_index[i]};
        assign partner = '{key: prev_data[J], idx: prev_index[J]};
        if ((i & DIST) == 0) begin : g_low
            assign p            = cmp_swap(prev_dir, own, partner);
            assign nxt_data[i]  = p.first.key;
            assign nxt_index[i] = p.first.idx;
        end else begin : g_high
            assign p            = cmp_swap(prev_dir, partner, own);
            assign nxt_data[i]  = p.second.key;
            assign nxt_index[i] = p.second.idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            dir   <= 1'b0;
            data  <= '0;
            index <= '0;
        end else if (en) begin
            valid <= prev_valid;
            dir   <= prev_dir;
            data  <= nxt_data;
            index <= nxt_index;
        end
    end
endmodule

// File: rtl/pipelined_bitonic_merge.sv
// Registered bitonic merger: log2(SIZE) compare-exchange ranks with one global stall.
module pipelined_bitonic_merge
    import pipelined_bitonic_merge_pkg::*;
#(
    parameter  int SIZE   = 4,
    localparam int STAGES = $clog2(SIZE),
    localparam int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_dir,
    input  logic [SIZE-1:0][NETWORK_WIDTH-1:0]  data_in,
    input  logic [SIZE-1:0][INDEX_WIDTH-1:0]    index_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_dir,
    output logic [SIZE-1:0][NETWORK_WIDTH-1:0]  data_out,
    output logic [SIZE-1:0][INDEX_WIDTH-1:0]    index_out,
    output logic [OCC_W-1:0]                    occupancy
);
    logic [STAGES:0]                  vld_pipe;
    logic [STAGES:0]                  dir_pipe;
    key_t [STAGES:0][SIZE-1:0]        key_pipe;
    idx_t [STAGES:0][SIZE-1:0]        idx_pipe;
    logic                             advance;

    // The whole pipe moves together; a stalled output freezes every rank.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign vld_pipe[0] = in_valid;
    assign dir_pipe[0] = in_dir;
    assign key_pipe[0] = data_in;
    assign idx_pipe[0] = index_in;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        merge_compare_stage #(
            .SIZE (SIZE),
            .DIST (SIZE >> (s + 1))
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .en         (advance),
            .prev_valid (vld_pipe[s]),
            .prev_dir   (dir_pipe[s]),
            .prev_data  (key_pipe[s]),
            .prev_index (idx_pipe[s]),
            .valid      (vld_pipe[s+1]),
            .dir        (dir_pipe[s+1]),
            .data       (key_pipe[s+1]),
            .index      (idx_pipe[s+1])
        );
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_dir   = dir_pipe[STAGES];
    assign data_out  = key_pipe[STAGES];
    assign index_out = idx_pipe[STAGES];

    always_comb begin
        occupancy = '0;
        for (int s = 1; s <= STAGES; s++)
            occupancy = occupancy + OCC_W'(vld_pipe[s]);
    end
endmodule

// File: tb/tb_pipelined_bitonic_merge.sv
// Directed checks of the SIZE=4 bitonic merger: sorting, ties, streaming, stall and reset flush.
module tb_pipelined_bitonic_merge;
    localparam int SIZE = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_dir;
    logic [3:0][7:0]      data_in;
    logic [3:0][3:0]      index_in;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_dir;
    logic [3:0][7:0]      data_out;
    logic [3:0][3:0]      index_out;
    logic [1:0]           occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    pipelined_bitonic_merge #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dir    (in_dir),
        .data_in   (data_in),
        .index_in  (index_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dir   (out_dir),
        .data_out  (data_out),
        .index_out (index_out),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0][7:0] keys(input int a0, input int a1, input int a2, input int a3);
        logic [3:0][7:0] k;
        k[0] = a0[7:0]; k[1] = a1[7:0]; k[2] = a2[7:0]; k[3] = a3[7:0];
        return k;
    endfunction

    function automatic logic [3:0][3:0] idxs(input int a0, input int a1, input int a2, input int a3);
        logic [3:0][3:0] x;
        x[0] = a0[3:0]; x[1] = a1[3:0]; x[2] = a2[3:0]; x[3] = a3[3:0];
        return x;
    endfunction

    // Bitonic test vector k: rises to k+20 then falls to k+5.
    function automatic logic [3:0][7:0] bvec(input int k);
        return keys(k, k + 10, k + 20, k + 5);
    endfunction

    function automatic logic [3:0][7:0] bvec_sorted(input int k, input logic d);
        return d ? keys(k, k + 5, k + 10, k + 20) : keys(k + 20, k + 10, k + 5, k);
    endfunction

    function automatic logic [3:0][3:0] bvec_idx(input logic d);
        return d ? idxs(0, 3, 1, 2) : idxs(2, 1, 3, 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_dir = 1'b0; out_ready = 1'b1;
        data_in = '0; index_in = idxs(0, 1, 2, 3);
        tick(); tick();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (data_out !== '0 || index_out !== '0 || out_dir !== 1'b0) begin
            n_bad++; $display("FAIL reset_outputs: got %h/%h/%b want 0/0/0", data_out, index_out, out_dir);
        end
    endtask

    task automatic test_sort_dir(input logic d, input logic [3:0][7:0] exp_d, input logic [3:0][3:0] exp_i);
        in_valid = 1'b1; in_dir = d; data_in = keys(1, 5, 7, 3); index_in = idxs(0, 1, 2, 3);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL sort_latency_early: got %b want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL sort_valid dir=%b: got %b want 1", d, out_valid); end
        n_cmp++; if (data_out !== exp_d) begin n_bad++; $display("FAIL sort_data dir=%b: got %h want %h", d, data_out, exp_d); end
        n_cmp++; if (index_out !== exp_i) begin n_bad++; $display("FAIL sort_index dir=%b: got %h want %h", d, index_out, exp_i); end
        n_cmp++; if (out_dir !== d) begin n_bad++; $display("FAIL sort_out_dir: got %b want %b", out_dir, d); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL sort_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_equal_keys(input logic d);
        in_valid = 1'b1; in_dir = d; data_in = keys(9, 9, 9, 9); index_in = idxs(0, 1, 2, 3);
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || data_out !== keys(9, 9, 9, 9)) begin
            n_bad++; $display("FAIL equal_data dir=%b: got %b/%h want 1/%h", d, out_valid, data_out, keys(9, 9, 9, 9));
        end
        n_cmp++; if (index_out !== idxs(0, 1, 2, 3)) begin
            n_bad++; $display("FAIL equal_index dir=%b: got %h want %h", d, index_out, idxs(0, 1, 2, 3));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            if (t - 1 < 8) begin
                in_valid = 1'b1; in_dir = t[0]; data_in = bvec(10 * (t - 1)); index_in = idxs(0, 1, 2, 3);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready t=%0d: got %b want 1", t, in_ready); end
            if (t >= 2 && t <= 9) begin
                // vector t-2 was driven with dir = (t-1) bit 0
                automatic int v = t - 2;
                automatic logic vd = v[0] ^ 1'b1;
                n_cmp++; if (out_valid !== 1'b1 || data_out !== bvec_sorted(10 * v, vd) ||
                             index_out !== bvec_idx(vd) || out_dir !== vd) begin
                    n_bad++; $display("FAIL b2b_result t=%0d: got %b %h %h %b want 1 %h %h %b",
                                      t, out_valid, data_out, index_out, out_dir,
                                      bvec_sorted(10 * v, vd), bvec_idx(vd), vd);
                end
            end else begin
                n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle t=%0d: got %b want 0", t, out_valid); end
            end
            if (t >= 2 && t <= 8) begin
                n_cmp++; if (occupancy !== 2'd2) begin n_bad++; $display("FAIL b2b_occupancy t=%0d: got %0d want 2", t, occupancy); end
            end
        end
    endtask

    task automatic test_stall();
        int sent = 0, recv = 0;
        logic have_snap = 1'b0;
        logic [3:0][7:0] snap_d;
        logic [3:0][3:0] snap_i;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            out_ready = (c >= 5);
            in_valid  = (sent < 6);
            in_dir    = 1'b1;
            data_in   = bvec(40 + 30 * sent);
            index_in  = idxs(0, 1, 2, 3);
            #1;
            if (c == 4) begin
                n_cmp++; if (occupancy !== 2'd2) begin n_bad++; $display("FAIL stall_occupancy: got %0d want 2", occupancy); end
                n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
            end
            if (out_valid && !out_ready) begin
                if (have_snap) begin
                    n_cmp++; if (data_out !== snap_d || index_out !== snap_i) begin
                        n_bad++; $display("FAIL stall_hold c=%0d: got %h/%h want %h/%h", c, data_out, index_out, snap_d, snap_i);
                    end
                end else begin
                    have_snap = 1'b1; snap_d = data_out; snap_i = index_out;
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++; if (data_out !== bvec_sorted(40 + 30 * recv, 1'b1) || index_out !== bvec_idx(1'b1)) begin
                    n_bad++; $display("FAIL stall_order #%0d: got %h/%h want %h/%h", recv, data_out, index_out,
                                      bvec_sorted(40 + 30 * recv, 1'b1), bvec_idx(1'b1));
                end
                recv++;
                have_snap = 1'b0;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++; if (recv !== 6) begin n_bad++; $display("FAIL stall_count: got %0d want 6", recv); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_duplicate: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_dir = 1'b1; data_in = bvec(100); index_in = idxs(0, 1, 2, 3);
        tick(); tick();
        n_cmp++; if (occupancy !== 2'd2) begin n_bad++; $display("FAIL flush_prefill: got %0d want 2", occupancy); end
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL flush_state: got v=%b occ=%0d rdy=%b want 0 0 1", out_valid, occupancy, in_ready);
        end
        n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL flush_data: got %h want 0", data_out); end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_ghost c=%0d: got %b want 0", c, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_sort_dir(1'b1, keys(1, 3, 5, 7), idxs(0, 3, 1, 2));
        test_sort_dir(1'b0, keys(7, 5, 3, 1), idxs(2, 1, 3, 0));
        test_equal_keys(1'b1);
        test_equal_keys(1'b0);
        test_back_to_back();
        test_stall();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
